// File: rtl/btn_mmio_reader_pkg.sv
// btn_mmio_pkg: register offsets and button count shared by the button port
package btn_mmio_pkg;
  localparam int NUM_BTN = 4;
  localparam logic [1:0] OFF_STATE  = 2'd0;
  localparam logic [1:0] OFF_EVENTS = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;
endpackage

// File: rtl/btn_mmio_reader_if.sv
// btn_mmio_reader_if: MEM-stage load/store bus between the CPU and the button port
interface btn_mmio_reader_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        sel;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, we, addr, wdata, input sel, ack, rdata);
  modport slave  (input req, we, addr, wdata, output sel, ack, rdata);
endinterface

// File: rtl/btn_mmio_reader_debounce.sv
// btn_debounce: two-flop synchronizer plus stable-count debouncer with a press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic stable,
  output logic rise
);
  logic [1:0]  sync;
  logic [23:0] cnt;
  logic        flip;
  // flip marks the edge on which stable toggles, so the press pulse lines up with it
  assign flip = (sync[1] != stable) && (cnt == 24'(DEBOUNCE_CYCLES - 1));
  assign rise = flip & ~stable;
  // synchronize the raw level and count consecutive cycles of disagreement
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      cnt  <= (sync[1] == stable || flip) ? '0 : cnt + 24'd1;
      if (flip) stable <= ~stable;
    end
endmodule

// File: rtl/btn_mmio_reader.sv
// btn_mmio_reader: memory-mapped push-button port with debounce, press events, counts and irq
module btn_mmio_reader
  import btn_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
  parameter int          DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  btn_mmio_reader_if.slave   bus,
  output logic               irq
);
  logic [NUM_BTN-1:0]      stable, rise, events, clr;
  logic [NUM_BTN-1:0][7:0] count;
  logic                    irq_en, hit, wr;
  logic [1:0]              off;
  logic [31:0]             rd_mux;
  logic                    unused_bits;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn    (btn[i]),
      .stable (stable[i]),
      .rise   (rise[i])
    );
  end
  assign bus.sel     = bus.addr[31:4] == BASE_ADDR[31:4];
  assign off         = bus.addr[3:2];
  assign hit         = bus.req & bus.sel;
  assign wr          = hit & bus.we;
  assign clr         = (wr && off == OFF_EVENTS) ? bus.wdata[NUM_BTN-1:0] : '0;
  assign unused_bits = ^{bus.wdata[31:4], bus.addr[1:0]};
  assign rd_mux = off == OFF_STATE  ? {28'd0, stable} :
                  off == OFF_EVENTS ? {28'd0, events} :
                  off == OFF_COUNT  ? count :
                                      {31'd0, irq_en};
  // register file: a press sets its event bit even when a clear lands on the same edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      events <= '0;
      count  <= '0;
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      events <= (events & ~clr) | rise;
      for (int n = 0; n < NUM_BTN; n++) count[n] <= count[n] + 8'(rise[n]);
      if (wr && off == OFF_CTRL) irq_en <= bus.wdata[0];
      irq <= irq_en & |events;
    end
  // bus response: one-cycle ack, load data sampled from pre-edge register contents
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack   <= hit;
      bus.rdata <= (hit && !bus.we) ? rd_mux : '0;
    end
endmodule

// File: tb/tb_btn_mmio_reader.sv
// tb_btn_mmio_reader: randomized self-checking bench against a register-level button model
module tb_btn_mmio_reader;
  import btn_mmio_pkg::*;
  localparam int DC = 4;
  localparam logic [31:0] BASE = 32'h2000;
  logic       clk = 0;
  logic       reset = 0;
  logic [3:0] btn = 0;
  logic       irq;
  int checks = 0;
  int errors = 0;
  btn_mmio_reader_if bus ();
  btn_mmio_reader #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .bus   (bus),
    .irq   (irq)
  );
  always #5 clk = ~clk;
  logic [3:0] m_state, m_ev;
  logic [7:0] m_cnt [4];
  logic       m_en;
  function automatic void m_reset();
    m_state = 0;
    m_ev = 0;
    m_en = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endfunction
  function automatic void m_level(input logic [3:0] lv);
    for (int i = 0; i < 4; i++)
      if (lv[i] && !m_state[i]) begin
        m_ev[i] = 1;
        m_cnt[i] = m_cnt[i] + 8'd1;
      end
    m_state = lv;
  endfunction
  function automatic logic [31:0] m_reg(input logic [1:0] off);
    case (off)
      2'd0:    return {28'd0, m_state};
      2'd1:    return {28'd0, m_ev};
      2'd2:    return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
      default: return {31'd0, m_en};
    endcase
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic ack_o, output logic [31:0] rd_o);
    bus.req = 1;
    bus.we = w;
    bus.addr = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.req = 0;
    bus.we = 0;
    ack_o = bus.ack;
    rd_o = bus.rdata;
  endtask
  task automatic hold_btn(input logic [3:0] v, input int n);
    btn = v;
    idle(n);
    m_level(v);
  endtask
  task automatic test_reset();
    logic a;
    logic [31:0] r;
    idle(2);
    checks++;
    if ({bus.ack, bus.rdata, irq} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs ack=%0b rdata=%h irq=%0b expected all 0", bus.ack, bus.rdata, irq);
    end
    reset = 1;
    m_reset();
    idle(1);
    for (int o = 0; o < 4; o++) begin
      xfer(0, BASE + 32'(4 * o), 0, a, r);
      checks++;
      if (a !== 1'b1 || r !== 32'd0) begin
        errors++;
        $display("FAIL reset_read off=%0d ack=%0b rdata=%h expected ack=1 rdata=0", o, a, r);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq irq=%0b expected 0", irq);
    end
  endtask
  task automatic test_hold();
    logic a;
    logic [31:0] r;
    hold_btn(4'b0010, 20);
    for (int o = 0; o < 3; o++) begin
      xfer(0, BASE + 32'(4 * o), 0, a, r);
      checks++;
      if (a !== 1'b1 || r !== m_reg(2'(o))) begin
        errors++;
        $display("FAIL hold_read off=%0d ack=%0b rdata=%h expected %h", o, a, r, m_reg(2'(o)));
      end
    end
    hold_btn(0, 20);
    xfer(1, BASE + 4, 32'hF, a, r);
    m_ev = 0;
  endtask
  task automatic test_glitch();
    logic a;
    logic [31:0] r;
    btn = 4'b0001;
    idle(3);
    btn = 0;
    idle(10);
    for (int o = 0; o < 3; o++) begin
      xfer(0, BASE + 32'(4 * o), 0, a, r);
      checks++;
      if (a !== 1'b1 || r !== m_reg(2'(o))) begin
        errors++;
        $display("FAIL glitch_read off=%0d ack=%0b rdata=%h expected %h", o, a, r, m_reg(2'(o)));
      end
    end
  endtask
  task automatic test_irq();
    logic a;
    logic [31:0] r;
    xfer(1, BASE + 12, 32'h1, a, r);
    m_en = 1;
    hold_btn(4'b1000, 20);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set irq=%0b expected 1", irq);
    end
    xfer(1, BASE + 4, 32'h8, a, r);
    m_ev[3] = 0;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_write_edge irq=%0b expected 1", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear irq=%0b expected 0", irq);
    end
    hold_btn(0, 20);
  endtask
  task automatic test_wrap();
    logic a;
    logic [31:0] r;
    logic [7:0] base;
    base = m_cnt[2];
    repeat (257) begin
      hold_btn(4'b0100, 8);
      hold_btn(0, 8);
    end
    xfer(0, BASE + 8, 0, a, r);
    checks++;
    if (a !== 1'b1 || r !== m_reg(2) || r[23:16] !== base + 8'd1) begin
      errors++;
      $display("FAIL wrap_count ack=%0b rdata=%h expected %h", a, r, m_reg(2));
    end
    xfer(1, BASE + 4, 32'hF, a, r);
    m_ev = 0;
  endtask
  task automatic test_same_edge();
    logic a1, a2;
    logic [31:0] r1, r2;
    btn = 4'b0100;
    idle(1);
    bus.req = 1;
    bus.we = 1;
    bus.addr = BASE + 4;
    bus.wdata = 32'h4;
    idle(2 + DC - 1);
    bus.we = 0;
    bus.addr = BASE;
    idle(1);
    a1 = bus.ack;
    r1 = bus.rdata;
    bus.addr = BASE + 4;
    idle(1);
    bus.req = 0;
    a2 = bus.ack;
    r2 = bus.rdata;
    m_level(4'b0100);
    checks++;
    if (a1 !== 1'b1 || r1 !== m_reg(0)) begin
      errors++;
      $display("FAIL same_edge_state ack=%0b rdata=%h expected %h", a1, r1, m_reg(0));
    end
    checks++;
    if (a2 !== 1'b1 || r2 !== m_reg(1)) begin
      errors++;
      $display("FAIL same_edge_events ack=%0b rdata=%h expected %h", a2, r2, m_reg(1));
    end
    hold_btn(0, 10);
    xfer(1, BASE + 4, 32'h4, a1, r1);
    m_ev[2] = 0;
  endtask
  task automatic test_miss();
    logic a;
    logic [31:0] r;
    hold_btn(4'b0001, 20);
    bus.req = 1;
    bus.we = 1;
    bus.addr = 32'h3004;
    bus.wdata = 32'hF;
    #1;
    checks++;
    if (bus.sel !== 1'b0) begin
      errors++;
      $display("FAIL miss_sel sel=%0b expected 0", bus.sel);
    end
    bus.addr = BASE + 12;
    #1;
    checks++;
    if (bus.sel !== 1'b1) begin
      errors++;
      $display("FAIL hit_sel sel=%0b expected 1", bus.sel);
    end
    bus.addr = 32'h3004;
    idle(1);
    bus.req = 0;
    checks++;
    if (bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL miss_ack ack=%0b expected 0", bus.ack);
    end
    xfer(1, BASE, 32'hF, a, r);
    xfer(1, BASE + 8, 32'hFFFF_FFFF, a, r);
    checks++;
    if (a !== 1'b1) begin
      errors++;
      $display("FAIL ro_write_ack ack=%0b expected 1", a);
    end
    for (int o = 0; o < 3; o++) begin
      xfer(0, BASE + 32'(4 * o) + 32'(o), 0, a, r);
      checks++;
      if (a !== 1'b1 || r !== m_reg(2'(o))) begin
        errors++;
        $display("FAIL miss_read off=%0d ack=%0b rdata=%h expected %h", o, a, r, m_reg(2'(o)));
      end
    end
    hold_btn(0, 20);
  endtask
  task automatic test_random();
    logic a;
    logic [31:0] r, d;
    logic [1:0] o;
    for (int it = 0; it < 60; it++) begin
      d = $urandom;
      case ($urandom_range(0, 5))
        0: hold_btn(4'(d), 12);
        1: begin
          btn = m_state ^ 4'(d | 32'h1);
          idle($urandom_range(1, DC - 1));
          btn = m_state;
          idle(4);
        end
        2: begin
          o = 2'($urandom_range(0, 3));
          xfer(0, BASE + {28'd0, o, 2'd0} + 32'(d[1:0]), 0, a, r);
          checks++;
          if (a !== 1'b1 || r !== m_reg(o)) begin
            errors++;
            $display("FAIL rand_read off=%0d ack=%0b rdata=%h expected %h", o, a, r, m_reg(o));
          end
        end
        3: begin
          xfer(1, BASE + 4, d, a, r);
          m_ev = m_ev & ~d[3:0];
        end
        4: begin
          xfer(1, BASE + 12, d, a, r);
          m_en = d[0];
        end
        default: xfer(1, d[4] ? BASE : BASE + 8, d, a, r);
      endcase
      idle(1);
      checks++;
      if (irq !== (m_en & |m_ev)) begin
        errors++;
        $display("FAIL rand_irq it=%0d irq=%0b expected %0b", it, irq, m_en & |m_ev);
      end
    end
    hold_btn(0, 12);
  endtask
  task automatic test_reset_mid();
    logic a;
    logic [31:0] r;
    xfer(1, BASE + 12, 32'h1, a, r);
    m_en = 1;
    hold_btn(4'b0001, 12);
    bus.req = 1;
    bus.we = 0;
    bus.addr = BASE + 8;
    idle(1);
    bus.req = 0;
    checks++;
    if (bus.ack !== 1'b1 || bus.rdata !== m_reg(2)) begin
      errors++;
      $display("FAIL mid_ack ack=%0b rdata=%h expected ack=1 rdata=%h", bus.ack, bus.rdata, m_reg(2));
    end
    #1;
    reset = 0;
    #1;
    checks++;
    if (bus.ack !== 1'b0 || bus.rdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset ack=%0b rdata=%h irq=%0b expected all 0", bus.ack, bus.rdata, irq);
    end
    btn = 0;
    idle(2);
    reset = 1;
    m_reset();
    idle(1);
    xfer(0, BASE + 8, 0, a, r);
    checks++;
    if (a !== 1'b1 || r !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_count ack=%0b rdata=%h expected 0", a, r);
    end
  endtask
  initial begin
    bus.req = 0;
    bus.we = 0;
    bus.addr = 0;
    bus.wdata = 0;
    m_reset();
    test_reset();
    test_hold();
    test_glitch();
    test_irq();
    test_wrap();
    test_same_edge();
    test_miss();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_mmio_reader.md
# btn_mmio_reader

Memory-mapped input peripheral that brings the four board push-buttons into the CPU's data address space, as the input counterpart of the LED output port in the MEM stage. It synchronizes and debounces each button, records press events and press counts, and answers single-cycle load/store requests from the MEM stage with registered read data. An interrupt-style level output flags pending press events.

## Interface
- `BASE_ADDR`, default 32'h0000_2000: 16-byte-aligned base of the 4-word register window.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change; legal range 2..2^24-1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `btn`  in  4  raw, asynchronous button levels, active-high.
- `req`  in  1  bus request valid this cycle.
- `we`  in  1  1 = store, 0 = load; qualified by `req`.
- `addr`  in  32  byte address from the MEM-stage ALU result.
- `wdata`  in  32  store data.
- `sel`  out  1  combinational: `addr` is inside the window; the MEM stage uses it to choose this block's read data.
- `ack`  out  1  registered one-cycle response to a selected request.
- `rdata`  out  32  registered read data, valid when `ack`=1, zero otherwise.
- `irq`  out  1  registered: `CTRL.irq_en` & |`EVENTS`.

## Operation
- Window hit: `addr[31:4]` == `BASE_ADDR[31:4]`; `addr[1:0]` ignored; offset = `addr[3:2]`.
- Registers:
  - 0x0 STATE (RO): [3:0] debounced button levels; [31:4] zero.
  - 0x4 EVENTS (RW1C): [3:0] sticky press flags; writing 1 clears a bit, writing 0 has no effect.
  - 0x8 COUNT (RO): byte i = press count of button i, 8-bit, wraps 255→0.
  - 0xC CTRL (RW): [0] irq_en; other bits read 0, writes ignored.
- Writes to STATE or COUNT are acknowledged and have no effect.
- Per button: 2-flop synchronizer → debouncer. The debouncer holds `stable`; while sync ≠ `stable`, a counter increments. When it reaches DEBOUNCE_CYCLES, `stable` toggles and the counter clears. Any cycle with sync == `stable` clears the counter.
- Press event: `stable` 0→1 sets EVENTS[i] and increments COUNT byte i in the same cycle. A 1→0 transition records nothing.
- Same-cycle set and W1C clear of one EVENTS bit: set wins.
- `req` with `sel`=0: no `ack`, no state change.

## Timing
- Reset (async assert, sync-to-clk release): all synchronizer flops, `stable`, counters, EVENTS, COUNT, and CTRL = 0; `ack`=0, `rdata`=0, `irq`=0.
- Read latency 1: request accepted at edge N, `ack`=1 with `rdata` during cycle N+1.
- Read data reflects register contents before edge N; a press that lands on edge N is visible on the next read.
- Back-to-back requests are legal every cycle; no stalls and no busywait.
- Write effect is visible from edge N; `irq` updates at edge N+1.
- Button-to-STATE latency: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 register cycle. Glitches shorter than DEBOUNCE_CYCLES never reach STATE.
- Reset asserted mid-transaction: a pending `ack` is dropped immediately.

## Structure
- Package `btn_mmio_pkg`: offset constants OFF_STATE=2'd0, OFF_EVENTS=2'd1, OFF_COUNT=2'd2, OFF_CTRL=2'd3; NUM_BTN=4.
- Sub-module `btn_debounce` (synchronizer + counter + `stable` + rise pulse, parameter DEBOUNCE_CYCLES), instantiated 4×. Decode, register file, and bus response live in the top.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and BASE_ADDR=32'h2000.
- Reset, then read 0x2000, 0x2004, 0x2008, 0x200C → each `ack` one cycle later with `rdata`=0; `irq`=0.
- Hold btn=4'b0010 for 20 cycles → STATE reads 0x2; EVENTS reads 0x2; COUNT reads 0x0000_0100.
- Pulse btn[0] high for 3 cycles → STATE, EVENTS, and COUNT stay 0.
- Set CTRL=1, press btn[3] → `irq`=1. Write EVENTS=0x8 → `irq`=0 one cycle after the write edge.
- Press and release btn[2] 257 times → COUNT byte 2 = 0x01. Arrange a press on the same edge as a W1C of bit 2 → EVENTS[2] stays 1.
- `req` at 0x3000 → `sel`=0, no `ack`. Assert reset during a read's `ack` cycle → `ack` and `rdata` go to 0 immediately.
